// File: rtl/y86_alu.sv
// Registered 64-bit Y86-64 execute ALU: add, sub, and, xor.
// Result, signed overflow, zero and sign flags appear one edge later.
module y86_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             zf,
    output logic             sf
);

    localparam int MSB = WIDTH - 1;

    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result;
    logic             sum_ovf;
    logic             result_ovf;

    // Shared adder: subtraction reuses the chain as a + ~b + 1.
    always_comb begin
        is_sub  = (control == 2'b01);
        b_op    = is_sub ? ~b : b;
        sum     = a + b_op + {{(WIDTH-1){1'b0}}, is_sub};
        sum_ovf = (a[MSB] == b_op[MSB]) && (sum[MSB] != a[MSB]);
    end

    // Operation select; logic ops never flag overflow.
    always_comb begin
        result     = '0;
        result_ovf = 1'b0;
        unique case (control)
            2'b00: begin
                result     = sum;
                result_ovf = sum_ovf;
            end
            2'b01: begin
                result     = sum;
                result_ovf = sum_ovf;
            end
            2'b10: result = a & b;
            2'b11: result = a ^ b;
        endcase
    end

    // Output registers; flags come from the same result being captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= '0;
            overflow <= 1'b0;
            zf       <= 1'b1;
            sf       <= 1'b0;
        end else begin
            out      <= result;
            overflow <= result_ovf;
            zf       <= (result == '0);
            sf       <= result[MSB];
        end
    end

endmodule

// File: tb/tb_y86_alu.sv
// Self-checking bench for y86_alu: directed table, reset and hold
// sequences, and random vectors against an arithmetic reference model.
module tb_y86_alu;

    typedef struct {
        logic [1:0]  ctl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] out;
        logic        ov;
        logic        zf;
        logic        sf;
    } vec_t;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [1:0]  control;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] out;
    logic        overflow;
    logic        zf;
    logic        sf;

    int n_vec;
    int n_bad;

    y86_alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .control  (control),
        .a        (a),
        .b        (b),
        .out      (out),
        .overflow (overflow),
        .zf       (zf),
        .sf       (sf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed arithmetic in 66 bits; overflow means the
    // true result does not fit back into 64 signed bits.
    function automatic vec_t model(input logic [1:0] c,
                                   input logic [63:0] x,
                                   input logic [63:0] y);
        vec_t v;
        logic signed [65:0] full;
        longint sx;
        longint sy;
        sx = longint'(x);
        sy = longint'(y);
        v.ctl = c;
        v.a   = x;
        v.b   = y;
        v.ov  = 1'b0;
        case (c)
            2'd0: begin
                full  = 66'(sx) + 66'(sy);
                v.out = full[63:0];
                v.ov  = (full != {{2{v.out[63]}}, v.out});
            end
            2'd1: begin
                full  = 66'(sx) - 66'(sy);
                v.out = full[63:0];
                v.ov  = (full != {{2{v.out[63]}}, v.out});
            end
            2'd2: v.out = x & y;
            default: v.out = x ^ y;
        endcase
        v.zf = (v.out == 64'd0);
        v.sf = v.out[63];
        return v;
    endfunction

    task automatic drive(input vec_t v);
        control = v.ctl;
        a       = v.a;
        b       = v.b;
    endtask

    task automatic check(input string nm, input vec_t v);
        n_vec++;
        if (out !== v.out) begin
            n_bad++;
            $display("FAIL %s out got %h want %h", nm, out, v.out);
        end
        if (overflow !== v.ov) begin
            n_bad++;
            $display("FAIL %s overflow got %b want %b", nm, overflow, v.ov);
        end
        if (zf !== v.zf) begin
            n_bad++;
            $display("FAIL %s zf got %b want %b", nm, zf, v.zf);
        end
        if (sf !== v.sf) begin
            n_bad++;
            $display("FAIL %s sf got %b want %b", nm, sf, v.sf);
        end
    endtask

    vec_t tbl[$];
    vec_t rst_v;
    vec_t v;
    vec_t prev;

    initial begin
        n_vec = 0;
        n_bad = 0;

        // Directed vectors with hand-derived expectations.
        tbl.push_back('{2'b01, 64'h100, 64'd8, 64'hF8, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{2'b00, 64'hF8, 64'd8, 64'h100, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{2'b00, MAXP, 64'd1, MINN, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{2'b00, NEG1, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{2'b01, MINN, 64'd1, MAXP, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{2'b01, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE,
                        1'b0, 1'b0, 1'b1});
        tbl.push_back('{2'b10, 64'hF0F0, 64'hFF00, 64'hF000,
                        1'b0, 1'b0, 1'b0});
        tbl.push_back('{2'b11, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'd0,
                        1'b0, 1'b1, 1'b0});
        tbl.push_back('{2'b01, MINN, MINN, 64'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{2'b00, MINN, MINN, 64'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{2'b01, 64'd0, MINN, MINN, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{2'b10, NEG1, MINN, MINN, 1'b0, 1'b0, 1'b1});

        rst_v = '{2'b00, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0};

        rst_n   = 1'b0;
        control = 2'b00;
        a       = '0;
        b       = '0;
        #12;
        check("reset_init", rst_v);

        // Load a nonzero result so the async reset has something to clear.
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(tbl[2]);
        @(posedge clk);
        #1 check("pre_reset", tbl[2]);

        // Async reset mid-cycle with garbage inputs, no clock edge.
        control = 2'b11;
        a = 64'hA5A5_5A5A_1234_5678;
        b = 64'h0F0F_F0F0_8765_4321;
        #1 rst_n = 1'b0;
        #1 check("reset_async", rst_v);
        @(posedge clk);
        #1 check("reset_hold", rst_v);

        // Release and run the first operation.
        rst_n = 1'b1;
        v = '{2'b00, 64'd5, 64'd3, 64'd8, 1'b0, 1'b0, 1'b0};
        drive(v);
        @(posedge clk);
        #1 check("first_op", v);

        // Inputs changing between edges must not reach the outputs.
        drive(tbl[7]);
        #3 check("hold_between", v);

        // Directed table, back-to-back one per cycle.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1 check($sformatf("dir%0d", i), tbl[i]);
        end

        // Directed vectors cross-checked against the reference model.
        for (int i = 0; i < tbl.size(); i++) begin
            v = model(tbl[i].ctl, tbl[i].a, tbl[i].b);
            drive(v);
            @(posedge clk);
            #1 check($sformatf("mdl%0d", i), v);
        end

        // Random back-to-back vectors, some operands pulled to boundaries.
        for (int i = 0; i < 1000; i++) begin
            logic [1:0]  c;
            logic [63:0] x;
            logic [63:0] y;
            c = 2'($urandom_range(0, 3));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: x = MAXP;
                1: x = MINN;
                2: y = MINN;
                3: y = NEG1;
                default: ;
            endcase
            v = model(c, x, y);
            drive(v);
            @(posedge clk);
            #1 check($sformatf("rnd%0d", i), v);
        end

        // Reset dropped with an operation in flight discards it.
        prev = model(2'b00, 64'd7, 64'd9);
        drive(prev);
        #2 rst_n = 1'b0;
        #1 check("flight_reset", rst_v);
        @(posedge clk);
        #1 check("flight_hold", rst_v);
        rst_n = 1'b1;
        v = model(2'b01, 64'd20, 64'd22);
        drive(v);
        @(posedge clk);
        #1 check("post_flight", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
